// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipe and mul/div result inputs, FIFO handshake, pending mask, RF write port.
// Defining WB_BYPASS_EN adds the decode bypass lookup signals.
interface wb_arbiter_if;
  logic        pipe_valid;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        pipe_hold;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic [31:0] md_pend;
  logic [4:0]  wraddr;
  logic [31:0] wrdata;
  logic        wren;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_addr1;
  logic [4:0]  byp_addr2;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [31:0] byp_data1;
  logic [31:0] byp_data2;

  modport master (
    output pipe_valid, pipe_addr, pipe_data, md_valid, md_addr, md_data, byp_addr1, byp_addr2,
    input  pipe_hold, md_ready, md_pend, wraddr, wrdata, wren,
           byp_hit1, byp_hit2, byp_data1, byp_data2
  );
  modport slave (
    input  pipe_valid, pipe_addr, pipe_data, md_valid, md_addr, md_data, byp_addr1, byp_addr2,
    output pipe_hold, md_ready, md_pend, wraddr, wrdata, wren,
           byp_hit1, byp_hit2, byp_data1, byp_data2
  );
`else
  modport master (
    output pipe_valid, pipe_addr, pipe_data, md_valid, md_addr, md_data,
    input  pipe_hold, md_ready, md_pend, wraddr, wrdata, wren
  );
  modport slave (
    input  pipe_valid, pipe_addr, pipe_data, md_valid, md_addr, md_data,
    output pipe_hold, md_ready, md_pend, wraddr, wrdata, wren
  );
`endif
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipe results win the RF write port, mul/div results queue in a FIFO and fill idle slots.
// Optional feature macro WB_BYPASS_EN adds combinational write-port bypass lookups.
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    addr_mem_q [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          wren_q, wren_d, out_md_q, out_md_d;
  logic [4:0]    wraddr_q, wraddr_d;
  logic [31:0]   wrdata_q, wrdata_d;
  logic          pipe_win, pop, push, md_ready;
  logic [31:0]   ent_dec [DEPTH];
  logic [31:0]   pend;

  assign md_ready = (count_q != CW'(DEPTH));
  assign pipe_win = bus.pipe_valid && (bus.pipe_addr != 5'd0);
  assign pop      = !pipe_win && (count_q != '0);
  // Address-0 results complete the handshake but are dropped here.
  assign push     = bus.md_valid && md_ready && (bus.md_addr != 5'd0);

  always_comb begin
    wren_d   = 1'b0;
    out_md_d = 1'b0;
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    if (pipe_win) begin
      wren_d   = 1'b1;
      wraddr_d = bus.pipe_addr;
      wrdata_d = bus.pipe_data;
    end else if (pop) begin
      wren_d   = 1'b1;
      out_md_d = 1'b1;
      wraddr_d = addr_mem_q[rd_ptr_q];
      wrdata_d = data_mem_q[rd_ptr_q];
    end
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    starve_d = starve_q;
    if ((count_q == '0) || pop) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wren_q   <= 1'b0;
      out_md_q <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wren_q   <= wren_d;
      out_md_q <= out_md_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= bus.md_addr;
      data_mem_q[wr_ptr_q] <= bus.md_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [AW-1:0] slot_off;
    assign slot_off    = AW'(gi) - rd_ptr_q;
    assign ent_dec[gi] = (CW'(slot_off) < count_q) ? (32'd1 << addr_mem_q[gi]) : 32'd0;
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend = pend | ent_dec[i];
    end
    if (wren_q && out_md_q) begin
      pend = pend | (32'd1 << wraddr_q);
    end
    pend[0] = 1'b0;
  end

  assign bus.md_ready  = md_ready;
  assign bus.md_pend   = pend;
  assign bus.pipe_hold = (starve_q == SW'(STARVE_MAX));
  assign bus.wren      = wren_q;
  assign bus.wraddr    = wraddr_q;
  assign bus.wrdata    = wrdata_q;

`ifdef WB_BYPASS_EN
  assign bus.byp_hit1  = wren_q && (wraddr_q == bus.byp_addr1) && (bus.byp_addr1 != 5'd0);
  assign bus.byp_hit2  = wren_q && (wraddr_q == bus.byp_addr2) && (bus.byp_addr2 != 5'd0);
  assign bus.byp_data1 = wrdata_q;
  assign bus.byp_data2 = wrdata_q;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboarded bench for wb_arbiter: directed scenarios then random traffic against a queue-based model.
module tb_wb_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if bus();
  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [4:0] a; logic [31:0] d; int unsigned c; } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  wr_t         mq[$];
  exp_t        expq[$];
  int          starve;
  bit          o_v, o_md;
  logic [4:0]  o_a;
  logic [31:0] o_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    expq.delete();
    starve = 0;
    o_v = 0; o_md = 0; o_a = '0; o_d = '0;
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].a] = 1'b1;
    if (o_md) p[o_a] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic drive_idle();
    bus.pipe_valid = 0; bus.pipe_addr = '0; bus.pipe_data = '0;
    bus.md_valid = 0; bus.md_addr = '0; bus.md_data = '0;
`ifdef WB_BYPASS_EN
    bus.byp_addr1 = '0; bus.byp_addr2 = '0;
`endif
  endtask

  // One cycle: drive inputs, check registered/combinational outputs, advance the reference model.
  task automatic step(input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md);
    int  sz;
    bit  pipe_win, pop;
    wr_t h;
    exp_t e;
    @(negedge clk);
    bus.pipe_valid = pv; bus.pipe_addr = pa; bus.pipe_data = pd;
    bus.md_valid = mv; bus.md_addr = ma; bus.md_data = md;
`ifdef WB_BYPASS_EN
    bus.byp_addr1 = (cyc % 2 == 0) ? o_a : 5'($urandom_range(0, 31));
    bus.byp_addr2 = (cyc % 3 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
`endif
    #1;
    sz = mq.size();
    check("md_ready", bus.md_ready, sz < DEPTH);
    check("pipe_hold", bus.pipe_hold, starve == STARVE_MAX);
    check("md_pend", bus.md_pend, model_pend());
    check("wraddr", bus.wraddr, o_a);
    check("wrdata", bus.wrdata, o_d);
`ifdef WB_BYPASS_EN
    check("byp_hit1", bus.byp_hit1, o_v && (o_a == bus.byp_addr1) && (bus.byp_addr1 != 0));
    check("byp_hit2", bus.byp_hit2, o_v && (o_a == bus.byp_addr2) && (bus.byp_addr2 != 0));
    check("byp_data1", bus.byp_data1, o_d);
`endif
    pipe_win = pv && (pa != 0);
    pop      = !pipe_win && (sz > 0);
    starve   = (sz == 0 || pop) ? 0 : ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX);
    o_v = 0; o_md = 0;
    if (pipe_win) begin
      o_v = 1; o_a = pa; o_d = pd;
    end else if (pop) begin
      h = mq.pop_front();
      o_v = 1; o_md = 1; o_a = h.a; o_d = h.d;
    end
    if (o_v) begin
      e.a = o_a; e.d = o_d; e.c = cyc + 1;
      expq.push_back(e);
    end
    if (mv && sz < DEPTH && ma != 0) begin
      h.a = ma; h.d = md;
      mq.push_back(h);
    end
  endtask

  // Monitor: every RF write must match the oldest expected write, in the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && cyc > 0) begin
      if (bus.wren) begin
        if (expq.size() == 0) begin
          check("unexpected_wren", 1, 0);
        end else begin
          e = expq.pop_front();
          check("wr_cycle", cyc, e.c);
          check("wr_addr", bus.wraddr, e.a);
          check("wr_data", bus.wrdata, e.d);
        end
      end else if (expq.size() > 0 && expq[0].c == cyc) begin
        check("missed_wren", 0, 1);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    drive_idle();
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_wren", bus.wren, 0);
    check("rst_wraddr", bus.wraddr, 0);
    check("rst_wrdata", bus.wrdata, 0);
    check("rst_md_pend", bus.md_pend, 0);
    check("rst_md_ready", bus.md_ready, 1);
    check("rst_pipe_hold", bus.pipe_hold, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single pipe write.
    step(1, 5'd5, 32'h1234, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    // Single mul/div write through the FIFO.
    step(0, 0, 0, 1, 5'd7, 32'hDEAD);
    repeat (4) step(0, 0, 0, 0, 0, 0);

    // Fill FIFO under continuous pipe traffic, saturate starvation, then yield one bubble.
    for (int k = 0; k < 12; k++)
      step(1, 5'($urandom_range(1, 31)), $urandom, k < 4, 5'(10 + k), $urandom);
    step(0, 0, 0, 1, 5'd20, 32'h2020);
    step(1, 5'd1, 32'h1111, 1, 5'd20, 32'h2020);
    repeat (6) step(0, 0, 0, 0, 0, 0);

    // Pipe addr 0 is an idle slot; md addr 0 is discarded.
    step(0, 0, 0, 1, 5'd3, 32'h3333);
    step(1, 5'd0, 32'hBAD, 0, 0, 0);
    step(0, 0, 0, 1, 5'd0, 32'h0BAD);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-operation with 3 queued entries and a write in flight.
    step(1, 5'd2, 32'h22, 1, 5'd4, 32'h44);
    step(1, 5'd2, 32'h23, 1, 5'd5, 32'h55);
    step(1, 5'd2, 32'h24, 1, 5'd6, 32'h66);
    step(1, 5'd8, 32'h88, 0, 0, 0);
    @(negedge clk);
    #2;
    check("pre_rst_wren", bus.wren, 1);
    rst = 1'b1;
    #1;
    check("async_rst_wren", bus.wren, 0);
    check("async_rst_md_pend", bus.md_pend, 0);
    check("async_rst_md_ready", bus.md_ready, 1);
    check("async_rst_pipe_hold", bus.pipe_hold, 0);
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Random traffic; upstream mostly honours pipe_hold.
    for (int k = 0; k < 600; k++) begin
      bit pv;
      pv = (starve == STARVE_MAX) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
      step(pv, 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end
    repeat (10) step(0, 0, 0, 0, 0, 0);
    check("scoreboard_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
